wbdma: RTL and testbench



---
 rtl/wbdma.sv | 170 +++++++++++++++++
 tb/tb_wbdma.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbdma.sv
// wbdma: CSR-programmed memory-to-memory copy engine acting as a Wishbone
// initiator. It moves 32-bit words one at a time (read, idle, write, idle),
// then sets a sticky DONE flag and pulses irq.
module wbdma #(
    parameter logic [3:0] csr_addr = 4'h2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic [2:0]  wbm_cti_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    output logic        irq
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_GAP1 = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_GAP2 = 3'd4;

    logic [2:0]  state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [31:0] data_buf;

    logic        csr_sel;
    logic        csr_wr;
    logic [1:0]  reg_idx;
    logic        ctrl_wr;
    logic        unused_addr_bits;

    assign csr_sel = (csr_a[13:10] == csr_addr);
    assign csr_wr  = csr_sel && csr_we;
    assign reg_idx = csr_a[1:0];
    assign ctrl_wr = csr_wr && (reg_idx == 2'd3);

    // Only the page and register index take part in decoding.
    assign unused_addr_bits = ^csr_a[9:2];

    // Byte lanes and cycle type never change: full-word classic cycles only.
    assign wbm_sel_o = 4'hf;
    assign wbm_cti_o = 3'b000;

    // Register readback; the page gate keeps csr_do at 0 so it can be OR-ed.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            csr_do <= 32'd0;
        end else if (csr_sel) begin
            case (reg_idx)
                2'd0:    csr_do <= src;
                2'd1:    csr_do <= dst;
                2'd2:    csr_do <= {16'd0, count};
                default: csr_do <= {30'd0, done, busy};
            endcase
        end else begin
            csr_do <= 32'd0;
        end
    end

    // CSR writes and the copy sequencer; later assignments to done win, so a
    // completion in the same cycle as a DONE clear leaves DONE set.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            src       <= 32'd0;
            dst       <= 32'd0;
            count     <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_buf  <= 32'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            irq       <= 1'b0;
        end else begin
            irq <= 1'b0;

            if (csr_wr && !busy) begin
                case (reg_idx)
                    2'd0:    src   <= {csr_di[31:2], 2'b00};
                    2'd1:    dst   <= {csr_di[31:2], 2'b00};
                    2'd2:    count <= csr_di[15:0];
                    default: ;
                endcase
            end

            if (ctrl_wr && csr_di[1]) begin
                done <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ctrl_wr && csr_di[0]) begin
                        if (count != 16'd0) begin
                            busy      <= 1'b1;
                            state     <= ST_RD;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_adr_o <= src;
                        end else begin
                            done <= 1'b1;
                            irq  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (wbm_ack_i) begin
                        data_buf  <= wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= ST_GAP1;
                    end
                end
                ST_GAP1: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_adr_o <= dst;
                    wbm_dat_o <= data_buf;
                    state     <= ST_WR;
                end
                ST_WR: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        src       <= src + 32'd4;
                        dst       <= dst + 32'd4;
                        count     <= count - 16'd1;
                        if (count == 16'd1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            irq   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GAP2;
                        end
                    end
                end
                ST_GAP2: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b0;
                    wbm_adr_o <= src;
                    state     <= ST_RD;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbdma.sv
// tb_wbdma: directed and randomized copies against a memory-backed Wishbone
// slave with programmable wait states; expectations come from the copy rules
// (words land in order, pointers advance by 4 per word, fixed cycle cost).
module tb_wbdma;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] readMem [0:1023];
    logic [31:0] wrMem [0:1023];
    logic [31:0] rdAddrLog [0:63];
    int          waitStates = 0;
    int          waitCnt = 0;
    int          rdN = 0;
    int          wrN = 0;
    int          irqCount = 0;
    int          cycCount = 0;
    int          stabErr = 0;
    int          cycleCnt = 0;
    logic        holdValid = 1'b0;
    logic [31:0] holdAdr, holdDat;
    logic        holdWe;

    always #5 sys_clk = ~sys_clk;

    wbdma #(.csr_addr(4'h2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_cti_o (wbm_cti_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (wbm_ack_i),
        .irq       (irq)
    );

    // Memory slave: acks after waitStates extra cycles, reads from readMem,
    // records writes into wrMem and logs every read address.
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            wbm_ack_i <= 1'b0;
            waitCnt   <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (waitCnt == waitStates) begin
                wbm_ack_i <= 1'b1;
                waitCnt   <= 0;
                if (wbm_we_o) begin
                    wrMem[wbm_adr_o[11:2]] <= wbm_dat_o;
                    wrN <= wrN + 1;
                end else begin
                    wbm_dat_i <= readMem[wbm_adr_o[11:2]];
                    rdAddrLog[rdN % 64] <= wbm_adr_o;
                    rdN <= rdN + 1;
                end
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end else begin
            wbm_ack_i <= 1'b0;
        end
    end

    // Event counters plus a check that a pending transaction holds still.
    always @(posedge sys_clk) begin
        cycleCnt <= cycleCnt + 1;
        if (irq) irqCount <= irqCount + 1;
        if (wbm_cyc_o) cycCount <= cycCount + 1;
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (holdValid && (wbm_adr_o !== holdAdr || wbm_we_o !== holdWe ||
                              wbm_dat_o !== holdDat))
                stabErr <= stabErr + 1;
            holdValid <= 1'b1;
            holdAdr   <= wbm_adr_o;
            holdWe    <= wbm_we_o;
            holdDat   <= wbm_dat_o;
        end else begin
            holdValid <= 1'b0;
        end
    end

    task automatic applyStimulus(input logic [1:0] idx, input logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = {4'h2, 8'h00, idx};
        csr_di = data;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csrRead(input logic [3:0] page, input logic [1:0] idx,
                           output logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = {page, 8'h00, idx};
        csr_we = 1'b0;
        @(negedge sys_clk);
        data = csr_do;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic doCopy(input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int w, input bit interfere);
        logic [31:0] expWords [$];
        logic [31:0] a;
        logic [31:0] r;
        int irq0, stab0, wr0, startCycle, t;
        bit seen;
        for (int i = 0; i < n; i++) begin
            a = src + 32'(4 * i);
            readMem[a[11:2]] = $urandom;
            expWords.push_back(readMem[a[11:2]]);
        end
        waitStates = w;
        applyStimulus(2'd3, 32'h2);
        csrRead(4'h2, 2'd3, r);
        checkOutput("ctrl_cleared", r, 32'h0);
        applyStimulus(2'd0, src);
        applyStimulus(2'd1, dst);
        applyStimulus(2'd2, 32'(n));
        irq0  = irqCount;
        stab0 = stabErr;
        wr0   = wrN;
        applyStimulus(2'd3, 32'h1);
        startCycle = cycleCnt;
        checkOutput("stb_after_start", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'h3);
        if (interfere) begin
            repeat (3) @(negedge sys_clk);
            applyStimulus(2'd1, 32'h0);
            applyStimulus(2'd2, 32'd9);
            applyStimulus(2'd3, 32'h1);
        end
        seen = 1'b0;
        t = 0;
        while (!seen && t < 5000) begin
            if (irq) seen = 1'b1;
            else begin
                @(negedge sys_clk);
                t++;
            end
        end
        checkOutput("irq_seen", {31'd0, seen}, 32'h1);
        checkOutput("latency", 32'(cycleCnt - startCycle + 1), 32'(n * (2 * w + 6)));
        repeat (2) @(negedge sys_clk);
        for (int i = 0; i < n; i++) begin
            a = dst + 32'(4 * i);
            checkOutput("dst_word", wrMem[a[11:2]], expWords[i]);
        end
        checkOutput("write_count", 32'(wrN - wr0), 32'(n));
        checkOutput("irq_pulses", 32'(irqCount - irq0), 32'h1);
        checkOutput("stable_wait", 32'(stabErr - stab0), 32'h0);
        csrRead(4'h2, 2'd0, r);
        checkOutput("final_src", r, src + 32'(4 * n));
        csrRead(4'h2, 2'd1, r);
        checkOutput("final_dst", r, dst + 32'(4 * n));
        csrRead(4'h2, 2'd2, r);
        checkOutput("final_count", r, 32'h0);
        csrRead(4'h2, 2'd3, r);
        checkOutput("final_ctrl", r, 32'h2);
    endtask

    // Watchdog so a stalled engine still produces a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by randomized copies.
    initial begin
        logic [31:0] r;
        int rd0, irq0, cyc0, t, n, w;
        logic [31:0] s, d;
        bit found;

        sys_rst = 1'b1;
        csr_a   = 14'd0;
        csr_we  = 1'b0;
        csr_di  = 32'd0;
        for (int i = 0; i < 1024; i++) readMem[i] = $urandom;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;

        checkOutput("rst_csr_do", csr_do, 32'h0);
        checkOutput("rst_adr", wbm_adr_o, 32'h0);
        checkOutput("rst_dat", wbm_dat_o, 32'h0);
        checkOutput("rst_ctl", {28'd0, wbm_we_o, wbm_cyc_o, wbm_stb_o, irq}, 32'h0);
        checkOutput("rst_sel", {28'd0, wbm_sel_o}, 32'hf);
        checkOutput("rst_cti", {29'd0, wbm_cti_o}, 32'h0);
        csrRead(4'h2, 2'd3, r);
        checkOutput("rst_ctrl", r, 32'h0);
        csrRead(4'h2, 2'd2, r);
        checkOutput("rst_count", r, 32'h0);

        applyStimulus(2'd0, 32'h40000013);
        csrRead(4'h2, 2'd0, r);
        checkOutput("src_align", r, 32'h40000010);
        applyStimulus(2'd1, 32'hABCDEF07);
        csrRead(4'h2, 2'd1, r);
        checkOutput("dst_align", r, 32'hABCDEF04);
        applyStimulus(2'd2, 32'h00012345);
        csrRead(4'h2, 2'd2, r);
        checkOutput("count_trunc", r, 32'h00002345);
        csrRead(4'h3, 2'd0, r);
        checkOutput("other_page", r, 32'h0);

        doCopy(32'h40000000, 32'h40000100, 4, 0, 1'b0);

        applyStimulus(2'd3, 32'h2);
        applyStimulus(2'd2, 32'h0);
        irq0 = irqCount;
        cyc0 = cycCount;
        applyStimulus(2'd3, 32'h1);
        checkOutput("zero_irq", {31'd0, irq}, 32'h1);
        repeat (3) @(negedge sys_clk);
        checkOutput("zero_no_cyc", 32'(cycCount - cyc0), 32'h0);
        checkOutput("zero_irq_pulses", 32'(irqCount - irq0), 32'h1);
        csrRead(4'h2, 2'd3, r);
        checkOutput("zero_ctrl", r, 32'h2);

        rd0 = rdN;
        doCopy(32'hFFFFFFFC, 32'h40000200, 2, 3, 1'b0);
        checkOutput("wrap_rd_addr", rdAddrLog[(rd0 + 1) % 64], 32'h0);

        doCopy(32'h40000400, 32'h40000600, 3, 0, 1'b1);

        // Reset while a write is waiting for its ack.
        waitStates = 3;
        applyStimulus(2'd0, 32'h40000040);
        applyStimulus(2'd1, 32'h40000800);
        applyStimulus(2'd2, 32'd2);
        applyStimulus(2'd3, 32'h1);
        found = 1'b0;
        t = 0;
        while (!found && t < 50) begin
            if (wbm_cyc_o && wbm_we_o && !wbm_ack_i) found = 1'b1;
            else begin
                @(negedge sys_clk);
                t++;
            end
        end
        checkOutput("rst_reach_wr", {31'd0, found}, 32'h1);
        irq0 = irqCount;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checkOutput("rst_cyc_drop", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        sys_rst = 1'b0;
        csrRead(4'h2, 2'd3, r);
        checkOutput("rst_mid_ctrl", r, 32'h0);
        csrRead(4'h2, 2'd0, r);
        checkOutput("rst_mid_src", r, 32'h0);
        repeat (10) @(negedge sys_clk);
        checkOutput("rst_no_irq", 32'(irqCount - irq0), 32'h0);

        // Clear of DONE landing on the completion edge.
        waitStates = 0;
        applyStimulus(2'd0, 32'h40000080);
        applyStimulus(2'd1, 32'h40000900);
        applyStimulus(2'd2, 32'd1);
        applyStimulus(2'd3, 32'h1);
        found = 1'b0;
        t = 0;
        while (!found && t < 50) begin
            if (wbm_ack_i && wbm_we_o) found = 1'b1;
            else begin
                @(negedge sys_clk);
                t++;
            end
        end
        checkOutput("coll_reach_ack", {31'd0, found}, 32'h1);
        csr_a  = {4'h2, 8'h00, 2'd3};
        csr_di = 32'h2;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
        checkOutput("coll_irq", {31'd0, irq}, 32'h1);
        csrRead(4'h2, 2'd3, r);
        checkOutput("coll_done_kept", r, 32'h2);
        applyStimulus(2'd3, 32'h2);
        csrRead(4'h2, 2'd3, r);
        checkOutput("clear_done", r, 32'h0);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 10);
            w = $urandom_range(0, 3);
            s = 32'h40000000 + 32'(4 * $urandom_range(0, 150));
            d = 32'h40000000 + 32'(4 * $urandom_range(400, 550));
            doCopy(s, d, n, w, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
